debug_ctrl: RTL and testbench
=============================

Name: debug_ctrl

Overview:
- Parametrised successor to the single-DUT debug harness FSM.
- Owns a byte-programmable code ROM that serves the CPU's instruction port.
- Runs/halts the CPU, steps N retired instructions, and supports NUM_BKPT hardware PC breakpoints.
- Uses a valid/ready command interface with a completion pulse and a status code. Sits between the Python-UI bridge and the CPU top.

Parameters:
NUM_BKPT, 4, number of PC breakpoint registers (1..16)
ROM_BYTES, 32, code ROM size in bytes (power of 2, >=4)
STEP_W, 16, width of the step counter
XLEN, 32, CPU address/data width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_op  in  3  opcode: 0 NOP, 1 RUN, 2 STEP, 3 HALT, 4 SET_BKPT, 5 CLR_BKPT, 6 WR_ROM, 7 reserved
cmd_idx  in  $clog2(NUM_BKPT) (min 1)  breakpoint index for SET/CLR
cmd_arg  in  XLEN  RUN: unused; STEP: count; SET_BKPT: PC; WR_ROM: {addr[..:8], data[7:0]}
cmd_done  out  1  one-cycle completion pulse
cmd_status  out  2  valid with cmd_done: 0 OK, 1 BKPT, 2 HALTED, 3 ERR
bkpt_idx  out  $clog2(NUM_BKPT) (min 1)  index of the hit breakpoint, valid with status BKPT
cpu_halt  out  1  CPU stall request
cpu_retired  in  1  CPU retired an instruction this cycle
cpu_pc  in  XLEN  PC of the retiring instruction, valid with cpu_retired
imem_addr  in  XLEN  CPU fetch byte address
imem_data  out  XLEN  fetched word

Behaviour:
- Reset values:
  - state=IDLE, cmd_done=0, cmd_status=0, bkpt_idx=0, cpu_halt=1.
  - All breakpoints disabled; breakpoint PCs=0; ROM cleared to 0; step counter=0.
- States: IDLE, RUN, STEP, DONE.
- cmd_ready:
  - IDLE: 1.
  - RUN/STEP: 1 only when cmd_op==HALT.
  - DONE: 0.
- Accepted in IDLE at cycle T:
  - NOP: go to DONE, status OK.
  - SET_BKPT: store cmd_arg in breakpoint cmd_idx and enable it; status OK, or ERR if cmd_idx>=NUM_BKPT (no change).
  - CLR_BKPT: disable breakpoint cmd_idx; ERR if cmd_idx out of range.
  - WR_ROM: write rom[addr]=data; ERR, no write, if addr>=ROM_BYTES.
  - HALT: status HALTED.
  - Op 7: status ERR.
  - Each of the above ends with cmd_done=1 at T+1 (DONE), then IDLE at T+2.
  - RUN: go to RUN.
  - STEP: load counter with cmd_arg[STEP_W-1:0], treating 0 as 1; go to STEP.
- cpu_halt:
  - Combinational: 0 in RUN/STEP unless stop_now this cycle; 1 otherwise.
  - stop_now = cpu_retired && (any enabled bkpt PC==cpu_pc || (state==STEP && counter==1)).
  - Guarantees no retirement after the stopping instruction.
  - The CPU must not make cpu_retired combinationally dependent on cpu_halt.
- STEP: decrement the counter on each cpu_retired.
- On stop_now, go to DONE next cycle:
  - status BKPT (lowest matching index in bkpt_idx) when a breakpoint matched;
  - otherwise OK.
- HALT accepted in RUN/STEP, go to DONE with status HALTED; cpu_halt rises the cycle after acceptance.
- HALT accepted in the same cycle as stop_now: the stop_now status wins; exactly one cmd_done.
- A breakpoint hit on the final STEP retirement reports BKPT.
- Breakpoints fire on retired PC only. RUN started at a breakpoint PC halts after that instruction retires.
- ROM read:
  - imem_data is combinational, little-endian bytes rom[a], rom[a+1], rom[a+2], rom[a+3].
  - a=imem_addr mod ROM_BYTES; a+k also wraps mod ROM_BYTES.
- reset_n asserted mid-command: immediate return to reset values; no cmd_done issued.

Decomposition:
- debug_pkg: op codes, status codes, state enum, min-1 clog2 helper function.
- Sub-module dbg_bkpt_unit: NUM_BKPT PC/enable register bank with set/clear port.
  - Outputs: hit, priority-encoded lowest hit index.

Test Plan:
- Reset, program 8 bytes 0x13,0,0,0,0x93,0,0x10,0 via WR_ROM -> imem_addr=4 gives 0x00100093; each command sees cmd_done one cycle after acceptance, status OK.
- STEP arg=3 with cpu_retired every other cycle -> exactly 3 retirements with cpu_halt=0 between them; cmd_done status OK; cpu_halt=1 in the cycle of the 3rd retire.
- SET_BKPT idx1 PC=0x10 and idx3 PC=0x10, RUN, retire PCs 0x0,0x4,...,0x10 -> stop at 0x10, status BKPT, bkpt_idx=1.
- RUN, HALT accepted with no retire -> cmd_done status HALTED, cpu_halt=1 from the next cycle; in the same cycle, cmd_op=STEP is rejected (cmd_ready=0 in RUN).
- Error paths: WR_ROM addr=ROM_BYTES, SET_BKPT idx=NUM_BKPT, op 7 -> status ERR each, ROM and breakpoints unchanged; STEP arg=0 -> 1 retirement.
- imem_addr=ROM_BYTES-2 -> bytes rom[30], rom[31], rom[0], rom[1]; reset_n pulsed mid-STEP -> cpu_halt=1, ROM zeroed, no cmd_done.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared opcodes, status codes and FSM states for the debug controller and its
// command interface.
package debug_pkg;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_RUN      = 3'd1,
    OP_STEP     = 3'd2,
    OP_HALT     = 3'd3,
    OP_SET_BKPT = 3'd4,
    OP_CLR_BKPT = 3'd5,
    OP_WR_ROM   = 3'd6,
    OP_RSVD     = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    STS_OK     = 2'd0,
    STS_BKPT   = 2'd1,
    STS_HALTED = 2'd2,
    STS_ERR    = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Index width for an N-entry table; a single entry still gets one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debug_ctrl_if.sv
// Valid/ready command channel between the UI bridge (master) and the debug
// controller (slave), including the completion pulse and status.
interface debug_ctrl_if #(
  parameter int NUM_BKPT = 4,
  parameter int XLEN     = 32
);
  localparam int IDX_W = debug_pkg::clog2_min1(NUM_BKPT);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [IDX_W-1:0] cmd_idx;
  logic [XLEN-1:0]  cmd_arg;
  logic             cmd_done;
  logic [1:0]       cmd_status;
  logic [IDX_W-1:0] bkpt_idx;

  modport master (
    output cmd_valid, cmd_op, cmd_idx, cmd_arg,
    input  cmd_ready, cmd_done, cmd_status, bkpt_idx
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_idx, cmd_arg,
    output cmd_ready, cmd_done, cmd_status, bkpt_idx
  );

endinterface

// File: rtl/dbg_bkpt_unit.sv
// Bank of PC breakpoint registers with enables; reports a hit on the compared
// PC and the lowest matching index.
module dbg_bkpt_unit
  import debug_pkg::*;
#(
  parameter int NUM_BKPT = 4,
  parameter int XLEN     = 32,
  localparam int IDX_W   = clog2_min1(NUM_BKPT)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             set_i,
  input  logic             clr_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  cmp_pc_i,
  output logic             idx_ok_o,
  output logic             hit_o,
  output logic [IDX_W-1:0] hit_idx_o
);

  logic [XLEN-1:0]     pc_q [NUM_BKPT];
  logic [NUM_BKPT-1:0] en_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q <= '0;
      for (int i = 0; i < NUM_BKPT; i++) pc_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BKPT; i++) begin
        if (idx_i == IDX_W'(i)) begin
          if (set_i) begin
            pc_q[i] <= pc_i;
            en_q[i] <= 1'b1;
          end else if (clr_i) begin
            en_q[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Index range is decided by matching against real entries, so a
  // non-power-of-two bank rejects the spare encodings.
  always_comb begin
    idx_ok_o = 1'b0;
    for (int i = 0; i < NUM_BKPT; i++) begin
      if (idx_i == IDX_W'(i)) idx_ok_o = 1'b1;
    end
  end

  // Scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    hit_o     = 1'b0;
    hit_idx_o = '0;
    for (int i = NUM_BKPT - 1; i >= 0; i--) begin
      if (en_q[i] && (pc_q[i] == cmp_pc_i)) begin
        hit_o     = 1'b1;
        hit_idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/debug_ctrl.sv
// Debug controller: code ROM for the CPU fetch port, run/step/halt control and
// PC breakpoints behind a valid/ready command channel.
module debug_ctrl
  import debug_pkg::*;
#(
  parameter int NUM_BKPT  = 4,
  parameter int ROM_BYTES = 32,
  parameter int STEP_W    = 16,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  debug_ctrl_if.slave     cmd,
  output logic            cpu_halt,
  input  logic            cpu_retired,
  input  logic [XLEN-1:0] cpu_pc,
  input  logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] imem_data
);

  localparam int IDX_W = clog2_min1(NUM_BKPT);
  localparam int AW    = $clog2(ROM_BYTES);

  state_e            state_q, state_d;
  status_e           status_q, status_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]  bkpt_idx_q, bkpt_idx_d;
  logic [7:0]        rom_q [ROM_BYTES];

  logic             rom_we, bk_set, bk_clr, idx_ok, addr_ok;
  logic             hit, stop_now, ready;
  logic [IDX_W-1:0] hit_idx;
  logic [AW-1:0]    rd_a;
  logic             unused_imem;

  dbg_bkpt_unit #(
    .NUM_BKPT(NUM_BKPT),
    .XLEN    (XLEN)
  ) u_bkpt (
    .clk      (clk),
    .reset_n  (reset_n),
    .set_i    (bk_set),
    .clr_i    (bk_clr),
    .idx_i    (cmd.cmd_idx),
    .pc_i     (cmd.cmd_arg),
    .cmp_pc_i (cpu_pc),
    .idx_ok_o (idx_ok),
    .hit_o    (hit),
    .hit_idx_o(hit_idx)
  );

  assign addr_ok = (cmd.cmd_arg[XLEN-1:8] < (XLEN-8)'(ROM_BYTES));

  // Stop is resolved in the retiring cycle so cpu_halt blocks any further
  // retirement before the FSM leaves RUN/STEP.
  assign stop_now = cpu_retired &&
                    (hit || ((state_q == S_STEP) && (cnt_q == STEP_W'(1))));

  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    cnt_d      = cnt_q;
    bkpt_idx_d = bkpt_idx_q;
    ready      = 1'b0;
    cpu_halt   = 1'b1;
    rom_we     = 1'b0;
    bk_set     = 1'b0;
    bk_clr     = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (cmd.cmd_valid) begin
          state_d    = S_DONE;
          status_d   = STS_OK;
          bkpt_idx_d = '0;
          case (op_e'(cmd.cmd_op))
            OP_NOP:      ;
            OP_RUN:      state_d = S_RUN;
            OP_STEP: begin
              state_d = S_STEP;
              cnt_d   = (cmd.cmd_arg[STEP_W-1:0] == '0) ? STEP_W'(1)
                                                        : cmd.cmd_arg[STEP_W-1:0];
            end
            OP_HALT:     status_d = STS_HALTED;
            OP_SET_BKPT: if (idx_ok) bk_set = 1'b1; else status_d = STS_ERR;
            OP_CLR_BKPT: if (idx_ok) bk_clr = 1'b1; else status_d = STS_ERR;
            OP_WR_ROM:   if (addr_ok) rom_we = 1'b1; else status_d = STS_ERR;
            OP_RSVD:     status_d = STS_ERR;
            default:     status_d = STS_ERR;
          endcase
        end
      end
      S_RUN, S_STEP: begin
        ready    = (cmd.cmd_op == OP_HALT);
        cpu_halt = stop_now;
        if ((state_q == S_STEP) && cpu_retired) cnt_d = cnt_q - STEP_W'(1);
        if (stop_now) begin
          state_d    = S_DONE;
          status_d   = hit ? STS_BKPT : STS_OK;
          bkpt_idx_d = hit ? hit_idx : '0;
        end else if (cmd.cmd_valid && ready) begin
          state_d    = S_DONE;
          status_d   = STS_HALTED;
          bkpt_idx_d = '0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      status_q   <= STS_OK;
      cnt_q      <= '0;
      bkpt_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      cnt_q      <= cnt_d;
      bkpt_idx_q <= bkpt_idx_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ROM_BYTES; i++) rom_q[i] <= '0;
    end else if (rom_we) begin
      rom_q[cmd.cmd_arg[8 +: AW]] <= cmd.cmd_arg[7:0];
    end
  end

  // Little-endian word fetch; byte offsets wrap within the ROM.
  assign rd_a        = imem_addr[AW-1:0];
  assign unused_imem = ^imem_addr[XLEN-1:AW];

  always_comb begin
    imem_data = '0;
    for (int k = 0; k < XLEN / 8; k++) begin
      imem_data[8*k +: 8] = rom_q[rd_a + AW'(k)];
    end
  end

  assign cmd.cmd_ready  = ready;
  assign cmd.cmd_done   = (state_q == S_DONE);
  assign cmd.cmd_status = status_q;
  assign cmd.bkpt_idx   = bkpt_idx_q;

endmodule

// File: tb/tb_debug_ctrl.sv
// Directed bench for debug_ctrl with three breakpoints and a 32-byte ROM.
module tb_debug_ctrl;
  import debug_pkg::*;

  localparam int NB = 3;
  localparam int RB = 32;
  localparam int SW = 16;
  localparam int XL = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_halt;
  logic        cpu_retired = 1'b0;
  logic [31:0] cpu_pc = '0;
  logic [31:0] imem_addr = '0;
  logic [31:0] imem_data;

  int vectors     = 0;
  int miscompares = 0;

  debug_ctrl_if #(.NUM_BKPT(NB), .XLEN(XL)) cif ();

  debug_ctrl #(
    .NUM_BKPT (NB),
    .ROM_BYTES(RB),
    .STEP_W   (SW),
    .XLEN     (XL)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd        (cif),
    .cpu_halt   (cpu_halt),
    .cpu_retired(cpu_retired),
    .cpu_pc     (cpu_pc),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [1:0] idx, input logic [31:0] arg);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_idx   = idx;
    cif.cmd_arg   = arg;
  endtask

  // Command completing from IDLE: done one cycle after acceptance, then idle.
  task automatic idle_cmd(input logic [2:0] op, input logic [1:0] idx,
                          input logic [31:0] arg, input logic [1:0] exp_sts,
                          input string tag);
    drive(op, idx, arg);
    #1 chk({tag, "_rdy"}, cif.cmd_ready, 1);
    cyc();
    cif.cmd_valid = 1'b0;
    chk({tag, "_done"}, cif.cmd_done, 1);
    chk({tag, "_sts"}, cif.cmd_status, exp_sts);
    cyc();
    chk({tag, "_done_clr"}, cif.cmd_done, 0);
  endtask

  task automatic run_start(input string tag);
    drive(OP_RUN, 0, 0);
    #1 chk({tag, "_rdy"}, cif.cmd_ready, 1);
    cyc();
    cif.cmd_valid = 1'b0;
    chk({tag, "_halt0"}, cpu_halt, 0);
  endtask

  task automatic retire(input logic [31:0] pc, input logic exp_halt, input string tag);
    cpu_retired = 1'b1;
    cpu_pc      = pc;
    #1 chk(tag, cpu_halt, exp_halt);
    cyc();
    cpu_retired = 1'b0;
  endtask

  task automatic halt_cmd(input string tag);
    drive(OP_HALT, 0, 0);
    cyc();
    cif.cmd_valid = 1'b0;
    chk({tag, "_sts"}, cif.cmd_status, STS_HALTED);
    cyc();
  endtask

  logic [7:0] prog [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

  initial begin
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = '0;
    cif.cmd_idx   = '0;
    cif.cmd_arg   = '0;

    #2;
    chk("rst_halt", cpu_halt, 1);
    chk("rst_done", cif.cmd_done, 0);
    chk("rst_sts", cif.cmd_status, 0);
    chk("rst_bidx", cif.bkpt_idx, 0);
    chk("rst_rom", imem_data, 0);
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();

    for (int i = 0; i < 8; i++)
      idle_cmd(OP_WR_ROM, 0, (32'(i) << 8) | 32'(prog[i]), STS_OK, "wr_rom");
    imem_addr = 32'd4;
    #1 chk("imem4", imem_data, 32'h0010_0093);
    imem_addr = 32'd0;
    #1 chk("imem0", imem_data, 32'h0000_0013);

    // STEP 3 with a retirement every other cycle.
    drive(OP_STEP, 0, 32'd3);
    #1 chk("step_rdy", cif.cmd_ready, 1);
    cyc();
    cif.cmd_valid = 1'b0;
    chk("step_halt0", cpu_halt, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("step_gap_halt", cpu_halt, 0);
      chk("step_gap_done", cif.cmd_done, 0);
      retire(32'(i * 4), (i == 2), "step_ret_halt");
    end
    chk("step_done", cif.cmd_done, 1);
    chk("step_sts", cif.cmd_status, STS_OK);
    cyc();
    chk("step_done_clr", cif.cmd_done, 0);
    chk("step_idle_halt", cpu_halt, 1);

    // Two breakpoints on the same PC: the lower index is reported.
    idle_cmd(OP_SET_BKPT, 1, 32'h10, STS_OK, "set1");
    idle_cmd(OP_SET_BKPT, 2, 32'h10, STS_OK, "set2");
    run_start("bk_run");
    for (int pc = 0; pc <= 16; pc += 4)
      retire(32'(pc), (pc == 16), "bk_ret_halt");
    chk("bk_done", cif.cmd_done, 1);
    chk("bk_sts", cif.cmd_status, STS_BKPT);
    chk("bk_idx", cif.bkpt_idx, 1);
    cyc();

    // HALT during RUN; STEP offered first must be refused.
    run_start("h_run");
    drive(OP_STEP, 0, 32'd5);
    #1 chk("h_step_rej", cif.cmd_ready, 0);
    cyc();
    chk("h_step_done", cif.cmd_done, 0);
    chk("h_step_halt", cpu_halt, 0);
    drive(OP_HALT, 0, 0);
    #1 chk("h_rdy", cif.cmd_ready, 1);
    chk("h_halt_same", cpu_halt, 0);
    cyc();
    cif.cmd_valid = 1'b0;
    chk("h_done", cif.cmd_done, 1);
    chk("h_sts", cif.cmd_status, STS_HALTED);
    chk("h_halt_next", cpu_halt, 1);
    cyc();
    chk("h_done_clr", cif.cmd_done, 0);

    // HALT in the same cycle as a breakpoint stop: BKPT wins, single done.
    run_start("hb_run");
    drive(OP_HALT, 0, 0);
    cpu_retired = 1'b1;
    cpu_pc      = 32'h10;
    #1 chk("hb_halt", cpu_halt, 1);
    cyc();
    cif.cmd_valid = 1'b0;
    cpu_retired   = 1'b0;
    chk("hb_done", cif.cmd_done, 1);
    chk("hb_sts", cif.cmd_status, STS_BKPT);
    cyc();
    chk("hb_done_clr", cif.cmd_done, 0);

    // Error paths and simple IDLE commands.
    idle_cmd(OP_WR_ROM, 0, (32'(RB) << 8) | 32'hAA, STS_ERR, "wr_oob");
    imem_addr = 32'd0;
    #1 chk("wr_oob_rom", imem_data, 32'h0000_0013);
    idle_cmd(OP_SET_BKPT, 3, 32'h8, STS_ERR, "set_oob");
    idle_cmd(OP_CLR_BKPT, 3, 32'h0, STS_ERR, "clr_oob");
    idle_cmd(OP_RSVD, 0, 32'h0, STS_ERR, "op7");
    idle_cmd(OP_HALT, 0, 32'h0, STS_HALTED, "halt_idle");
    idle_cmd(OP_NOP, 0, 32'h0, STS_OK, "nop");
    idle_cmd(OP_CLR_BKPT, 1, 32'h0, STS_OK, "clr1");
    run_start("clr_run");
    retire(32'h8, 0, "clr_ret8");
    retire(32'h10, 1, "clr_ret10");
    chk("clr_sts", cif.cmd_status, STS_BKPT);
    chk("clr_idx", cif.bkpt_idx, 2);
    cyc();

    // STEP 0 behaves as STEP 1.
    drive(OP_STEP, 0, 32'd0);
    cyc();
    cif.cmd_valid = 1'b0;
    retire(32'h20, 1, "step0_halt");
    chk("step0_done", cif.cmd_done, 1);
    chk("step0_sts", cif.cmd_status, STS_OK);
    cyc();

    // Fetch wraps at the end of the ROM.
    idle_cmd(OP_WR_ROM, 0, (32'd30 << 8) | 32'hAB, STS_OK, "wr30");
    idle_cmd(OP_WR_ROM, 0, (32'd31 << 8) | 32'hCD, STS_OK, "wr31");
    imem_addr = 32'(RB - 2);
    #1 chk("imem_wrap", imem_data, 32'h0013_CDAB);

    // Reset in the middle of a STEP.
    drive(OP_STEP, 0, 32'd5);
    cyc();
    cif.cmd_valid = 1'b0;
    retire(32'h0, 0, "rst_step_ret");
    reset_n = 1'b0;
    #1 chk("mid_rst_halt", cpu_halt, 1);
    chk("mid_rst_done", cif.cmd_done, 0);
    chk("mid_rst_sts", cif.cmd_status, 0);
    imem_addr = 32'd4;
    #1 chk("mid_rst_rom4", imem_data, 0);
    imem_addr = 32'(RB - 2);
    #1 chk("mid_rst_romw", imem_data, 0);
    cyc();
    chk("mid_rst_done2", cif.cmd_done, 0);
    reset_n = 1'b1;
    cyc();
    chk("post_rst_done", cif.cmd_done, 0);
    chk("post_rst_halt", cpu_halt, 1);
    run_start("post_rst_run");
    retire(32'h10, 0, "post_rst_bk_clr");
    halt_cmd("post_rst_halt_cmd");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
